// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: mm:ss countdown FSM stepped by a 1 Hz tick strobe, with button configuration, pause/resume and a timed alarm.
// Optional build macro EGG_ALARM_BLINK_EN makes led_alarm blink at 0.5 Hz during ALARM instead of staying lit.
module egg_timer_ctrl #(
  parameter int MAX_MINS   = 99,
  parameter int ALARM_SECS = 10,
  parameter int MIN_W      = $clog2(MAX_MINS + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        tick,
  input  logic        cook_time,
  input  logic        start,
  input  logic        mins_inc,
  input  logic        secs_inc,
  input  logic        clr,
  output logic [15:0] digits,
  output logic [2:0]  state,
  output logic        done,
  output logic        led_run,
  output logic        led_alarm,
  output logic        led_en
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONFIG  = 3'd1,
    PAUSED  = 3'd2,
    RUNNING = 3'd3,
    ALARM   = 3'd4
  } state_t;

  localparam logic [MIN_W-1:0] MAX_M   = MIN_W'(MAX_MINS);
  localparam logic [7:0]       ALARM_N = 8'(ALARM_SECS);

  state_t           cur_state;
  logic [MIN_W-1:0] mins;
  logic [5:0]       secs;
  logic [7:0]       alarm_cnt;

  assign state  = cur_state;
  assign digits = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
      mins      <= '0;
      secs      <= '0;
      alarm_cnt <= '0;
      done      <= 1'b0;
      led_run   <= 1'b0;
      led_alarm <= 1'b0;
      led_en    <= 1'b0;
    end else begin
      done   <= 1'b0;
      led_en <= enable;
      if (cook_time) begin
        // Edits only apply once CONFIG is established; the entry cycle just cancels whatever was active.
        cur_state <= CONFIG;
        led_run   <= 1'b0;
        led_alarm <= 1'b0;
        alarm_cnt <= '0;
        if (cur_state == CONFIG) begin
          if (clr) begin
            mins <= '0;
            secs <= '0;
          end else begin
            if (mins_inc) mins <= (mins == MAX_M) ? '0 : mins + 1'b1;
            if (secs_inc) secs <= (secs == 6'd59) ? '0 : secs + 1'b1;
          end
        end
      end else if (!enable) begin
        if (cur_state == RUNNING) begin
          cur_state <= PAUSED;
          led_run   <= 1'b0;
        end else if (cur_state > ALARM) begin
          cur_state <= IDLE;
          led_run   <= 1'b0;
          led_alarm <= 1'b0;
        end
      end else begin
        case (cur_state)
          IDLE: ;
          CONFIG: cur_state <= (mins != '0 || secs != '0) ? PAUSED : IDLE;
          PAUSED: begin
            if (clr) begin
              mins      <= '0;
              secs      <= '0;
              cur_state <= IDLE;
            end else if (start) begin
              cur_state <= RUNNING;
              led_run   <= 1'b1;
            end
          end
          RUNNING: begin
            if (start) begin
              cur_state <= PAUSED;
              led_run   <= 1'b0;
            end else if (tick) begin
              if (mins == '0 && secs == 6'd1) begin
                secs      <= '0;
                cur_state <= ALARM;
                led_run   <= 1'b0;
                done      <= 1'b1;
                alarm_cnt <= '0;
                led_alarm <= 1'b1;
              end else if (secs != '0) begin
                secs <= secs - 1'b1;
              end else begin
                mins <= mins - 1'b1;
                secs <= 6'd59;
              end
            end
          end
          ALARM: begin
            if (start || (tick && alarm_cnt + 8'd1 == ALARM_N)) begin
              cur_state <= IDLE;
              led_alarm <= 1'b0;
              alarm_cnt <= '0;
            end else if (tick) begin
              alarm_cnt <= alarm_cnt + 8'd1;
`ifdef EGG_ALARM_BLINK_EN
              led_alarm <= ~led_alarm;
`else
              led_alarm <= 1'b1;
`endif
            end
          end
          default: begin
            cur_state <= IDLE;
            led_run   <= 1'b0;
            led_alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: directed scenarios plus randomized buttons/ticks against a total-seconds reference model.
module tb_egg_timer_ctrl;

  localparam int MAX_MINS   = 12;
  localparam int ALARM_SECS = 3;
  localparam int S_IDLE = 0, S_CONFIG = 1, S_PAUSED = 2, S_RUNNING = 3, S_ALARM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, enable = 1'b1, tick = 1'b0, cook_time = 1'b0;
  logic        start = 1'b0, mins_inc = 1'b0, secs_inc = 1'b0, clr = 1'b0;
  logic [15:0] digits;
  logic [2:0]  state;
  logic        done, led_run, led_alarm, led_en;

  int checks = 0;
  int errors = 0;

  int m_state = S_IDLE, m_mins = 0, m_secs = 0, m_alarm_ticks = 0;
  bit m_done = 0, m_led_alarm = 0, m_led_en = 0;

  egg_timer_ctrl #(.MAX_MINS(MAX_MINS), .ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .cook_time(cook_time),
    .start(start), .mins_inc(mins_inc), .secs_inc(secs_inc), .clr(clr),
    .digits(digits), .state(state), .done(done), .led_run(led_run),
    .led_alarm(led_alarm), .led_en(led_en)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int m, input int s);
    return 16'((m / 10) * 4096 + (m % 10) * 256 + (s / 10) * 16 + (s % 10));
  endfunction

  // Reference model: count kept as mm:ss, decrement done on total seconds.
  task automatic modelStep(input bit r, en, tk, ck, st, mi, si, cl);
    int total;
    m_done = 0;
    if (r) begin
      m_state = S_IDLE; m_mins = 0; m_secs = 0; m_alarm_ticks = 0;
      m_led_alarm = 0; m_led_en = 0;
      return;
    end
    m_led_en = en;
    if (ck) begin
      if (m_state == S_CONFIG) begin
        if (cl) begin
          m_mins = 0; m_secs = 0;
        end else begin
          if (mi) m_mins = (m_mins == MAX_MINS) ? 0 : m_mins + 1;
          if (si) m_secs = (m_secs + 1) % 60;
        end
      end
      m_state = S_CONFIG; m_led_alarm = 0;
    end else if (!en) begin
      if (m_state == S_RUNNING) m_state = S_PAUSED;
    end else begin
      case (m_state)
        S_CONFIG: m_state = (m_mins * 60 + m_secs != 0) ? S_PAUSED : S_IDLE;
        S_PAUSED:
          if (cl) begin m_mins = 0; m_secs = 0; m_state = S_IDLE; end
          else if (st) m_state = S_RUNNING;
        S_RUNNING:
          if (st) m_state = S_PAUSED;
          else if (tk) begin
            total = m_mins * 60 + m_secs - 1;
            m_mins = total / 60; m_secs = total % 60;
            if (total == 0) begin
              m_state = S_ALARM; m_done = 1; m_alarm_ticks = 0; m_led_alarm = 1;
            end
          end
        S_ALARM:
          if (st) begin m_state = S_IDLE; m_led_alarm = 0; end
          else if (tk) begin
            m_alarm_ticks++;
            if (m_alarm_ticks == ALARM_SECS) begin m_state = S_IDLE; m_led_alarm = 0; end
`ifdef EGG_ALARM_BLINK_EN
            else m_led_alarm = ~m_led_alarm;
`endif
          end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, en, tk, ck, st, mi, si, cl);
    rst = r; enable = en; tick = tk; cook_time = ck;
    start = st; mins_inc = mi; secs_inc = si; clr = cl;
    @(posedge clk);
    modelStep(r, en, tk, ck, st, mi, si, cl);
    #1;
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("digits", 32'(digits), 32'(bcd(m_mins, m_secs)));
    checkOutput("done", 32'(done), 32'(m_done));
    checkOutput("led_run", 32'(led_run), 32'(m_state == S_RUNNING));
    checkOutput("led_alarm", 32'(led_alarm), 32'(m_led_alarm));
    checkOutput("led_en", 32'(led_en), 32'(m_led_en));
  endtask

  // Load a value through CONFIG and leave cook_time low (PAUSED or IDLE afterwards).
  task automatic configure(input int mm, input int ss);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < mm; i++) applyStimulus(0, 1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < ss; i++) applyStimulus(0, 1, 0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ck_lvl;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_digits", 32'(digits), 32'h0);

    // Configure 02:05
    configure(2, 5);
    checkOutput("cfg_state", 32'(state), S_PAUSED);
    checkOutput("cfg_digits", 32'(digits), 32'h0205);

    // Countdown with borrow, then start+tick pauses without decrement
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("run_0200", 32'(digits), 32'h0200);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("borrow_0159", 32'(digits), 32'h0159);
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0);
    checkOutput("start_wins_state", 32'(state), S_PAUSED);
    checkOutput("start_wins_digits", 32'(digits), 32'h0159);

    // Reach zero, alarm, auto-return after ALARM_SECS ticks
    configure(0, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("zero_done", 32'(done), 32'h1);
    checkOutput("zero_state", 32'(state), S_ALARM);
    checkOutput("zero_led_alarm", 32'(led_alarm), 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("done_one_cycle", 32'(done), 32'h0);
    for (int i = 0; i < ALARM_SECS; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("alarm_timeout_state", 32'(state), S_IDLE);
    checkOutput("alarm_timeout_led", 32'(led_alarm), 32'h0);

    // Both wraps at once: 59 s and MAX_MINS -> 00:00, then IDLE
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_MINS; i++) applyStimulus(0, 1, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 59; i++) applyStimulus(0, 1, 0, 1, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 1, 0);
    checkOutput("double_wrap", 32'(digits), 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_idle", 32'(state), S_IDLE);

    // Enable drop pauses, ticks ignored, resume, then reset mid-run
    configure(0, 30);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("en_drop_state", 32'(state), S_PAUSED);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0, 1);
    checkOutput("en_hold_digits", 32'(digits), 32'h0030);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("resume_state", 32'(state), S_RUNNING);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_run", 32'(digits), 32'h0);

    // Alarm acknowledged by start
    configure(0, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    checkOutput("ack_state", 32'(state), S_IDLE);

    // Randomized traffic; start and clr never coincide
    ck_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, en, tk, st, mi, si, cl;
      int p;
      if ($urandom_range(0, 29) == 0) ck_lvl = ~ck_lvl;
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 11) != 0);
      tk = ($urandom_range(0, 2) == 0);
      mi = ($urandom_range(0, 9) == 0);
      si = ($urandom_range(0, 3) == 0);
      p  = int'($urandom_range(0, 19));
      st = (p < 3);
      cl = (p == 19);
      applyStimulus(r, en, tk, ck_lvl, st, mi, si, cl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
Parametrised successor of the egg-timer control FSM. Runs entirely in the single system clock domain and advances on a 1 Hz clock-enable strobe rather than a derived clock. Holds the mm:ss countdown value, handles button-driven time configuration and pause/resume, and raises a timed alarm at zero. Feeds packed BCD digits to the existing 7-segment multiplexer; button inputs come from the existing debouncers.

Parameters:
MAX_MINS, 99, upper minute limit for configuration; legal range 1..99.
ALARM_SECS, 10, ticks the alarm stays active before auto-return to IDLE; legal range 1..255.
MIN_W, $clog2(MAX_MINS+1), minute register width; derived, do not override.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  global run enable; low freezes the countdown
tick  in  1  one-clk-wide 1 Hz strobe
cook_time  in  1  level; high = configuration mode
start  in  1  one-clk pulse; start/pause/acknowledge
mins_inc  in  1  one-clk pulse; add one minute
secs_inc  in  1  one-clk pulse; add one second
clr  in  1  one-clk pulse; zero the count
digits  out  16  BCD {m_tens, m_ones, s_tens, s_ones}
state  out  3  IDLE=0, CONFIG=1, PAUSED=2, RUNNING=3, ALARM=4
done  out  1  one-clk pulse when the count reaches 00:00 while running
led_run  out  1  high in RUNNING
led_alarm  out  1  alarm indicator
led_en  out  1  registered copy of enable

Behaviour:
- Reset, synchronous, on the rst-high edge:
  - state=IDLE; mins=0, secs=0 (digits=16'h0000)
  - done=0, led_run=0, led_alarm=0, led_en=0, alarm counter=0
  - Reset mid-count or mid-alarm aborts immediately.
- Timing: every output changes on the clk edge that samples its cause, one cycle of latency. digits is a pure function of the mins/secs registers.
- Priority, highest first: rst > cook_time > enable=0 > start > tick.
- cook_time=1 in any state forces CONFIG the next cycle. The alarm is cancelled and done is not asserted.
- CONFIG:
  - mins_inc: mins+1; MAX_MINS wraps to 0.
  - secs_inc: secs+1; 59 wraps to 0 with no carry into minutes.
  - Both pulses in the same cycle: both apply.
  - clr: zeroes the count and wins over the inc pulses in the same cycle.
  - tick and start are ignored.
  - When cook_time falls: go to PAUSED if the count is nonzero, else IDLE.
- IDLE: start is ignored; the count is 0 except after a completed alarm (count is already 0).
- PAUSED:
  - start -> RUNNING.
  - clr -> count 0 and go to IDLE.
  - tick is ignored.
- RUNNING, on tick:
  - count==00:01 -> count=00:00, state=ALARM, done=1 for exactly one cycle.
  - otherwise, secs>0 -> secs-1; secs==0 -> mins-1 and secs=59.
- RUNNING, other events:
  - start -> PAUSED.
  - start and tick in the same cycle: start wins; no decrement.
  - clr is ignored.
- enable=0: RUNNING goes to PAUSED. Other states hold; inc, clr and start are ignored. led_en follows enable with one cycle of delay.
- ALARM:
  - Alarm counter is cleared on entry and incremented on each tick.
  - Reaching ALARM_SECS -> IDLE.
  - start pulse (acknowledge) -> IDLE on the next edge, overriding the counter.
  - led_alarm is low in every other state.
- The count can never be 00:00 in RUNNING; the decrement never underflows.
- Unused state encodings 5..7 recover to IDLE on the next clock.

Optional Feature:
Macro: EGG_ALARM_BLINK_EN.
- Defined: led_alarm toggles on each tick while in ALARM and starts at 1 on entry, giving a 0.5 Hz blink.
- Undefined: led_alarm is held steadily at 1 throughout ALARM.
- Both builds: led_alarm is 0 outside ALARM.

Test Plan:
- Reset, then cook_time=1, 2x mins_inc, 5x secs_inc, cook_time=0 -> state PAUSED, digits=16'h0205.
- From 02:05: start, then 5 ticks -> 02:00; 1 more tick -> 01:59 (borrow); start+tick in the same cycle -> PAUSED, digits stay 01:59.
- Count 00:01 RUNNING, one tick -> digits 0000, done high exactly 1 cycle, state ALARM; ALARM_SECS=3 and 3 ticks -> IDLE, led_alarm back to 0.
- CONFIG at 59 s and MAX_MINS: secs_inc and mins_inc in the same cycle -> 00:00; then cook_time=0 -> IDLE.
- RUNNING at 00:30, drop enable -> PAUSED next cycle, ticks ignored; enable=1, start -> resumes from 00:30; rst mid-run -> IDLE, 0000 on the next edge.
- ALARM with EGG_ALARM_BLINK_EN defined -> led_alarm sequence 1,0,1 across ticks; start pulse -> IDLE next cycle.
